bus_responder: RTL
==================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: ports clock and reset.
REQ-002 Parameter RAM_BYTES SHALL default to 64 and set the RAM size in bytes; it SHALL be a power of two, at most 64.
REQ-003 Parameter FIFO_DEPTH SHALL default to 4 and set the transmit FIFO depth in entries; it SHALL be a power of two, at least 2 and at most 8.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 address  input  8  CPU byte address.
REQ-007 write_enable  input  1  CPU write strobe; sampled every cycle.
REQ-008 write_data  input  8  CPU store data.
REQ-009 read_data  output  8  CPU load data; combinational.
REQ-010 port_data  output  8  transmit FIFO head byte.
REQ-011 port_valid  output  1  the FIFO holds at least one byte.
REQ-012 port_ready  input  1  the downstream consumer accepts port_data.

Function
REQ-013 Memory map:
- RAM: address >= 256-RAM_BYTES, i.e. the top of the space, which covers the downward-growing stack.
- 0x00 TXDATA
- 0x01 STATUS
- 0x02 TIMER
- 0x03 DROPS
- All other addresses: unmapped; they SHALL read 0x00 and ignore writes.
REQ-014 Reads SHALL be zero-latency: read_data is a combinational function of address and current state, with no handshake and no wait state.
REQ-015 A RAM write SHALL update the byte at index address mod RAM_BYTES on the clock edge where write_enable=1; a read in the same cycle SHALL return the old value.
REQ-016 A TXDATA write SHALL push write_data into the FIFO; a TXDATA read SHALL return 0x00.
REQ-017 STATUS SHALL be read-only and laid out as:
- bit0 = full
- bit1 = empty
- bits[5:2] = occupancy count
- bits[7:6] = 0
REQ-018 A pop SHALL occur on an edge where port_valid=1 and port_ready=1; port_data SHALL then present the next entry in the following cycle.
REQ-019 port_valid SHALL equal not-empty, and port_data SHALL be 0x00 when the FIFO is empty.
REQ-020 A push while full and not popping SHALL be discarded, and DROPS SHALL increment.
REQ-021 A push while full with a simultaneous pop SHALL be accepted, leaving occupancy unchanged.
REQ-022 A push while empty SHALL not be visible on port_valid until the next cycle; there is no fall-through.
REQ-023 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked separately with width clog2(FIFO_DEPTH)+1.
REQ-024 DROPS SHALL saturate at 0xFF; any write to 0x03 SHALL clear it to 0x00, and a clear SHALL take priority over a same-cycle increment.
REQ-025 TIMER SHALL be a free-running 8-bit counter that increments every cycle and wraps 0xFF->0x00; any write to 0x02 SHALL load 0x00 on that edge, and it SHALL count from 0x00 thereafter.

Reset
REQ-026 On reset:
- FIFO empty: port_valid=0, port_data=0x00, STATUS=0x02.
- Pointers = 0; TIMER = 0x00; DROPS = 0x00.
- RAM contents are not reset.
REQ-027 Reset asserted mid-stream SHALL discard all queued bytes immediately (asynchronously); no pop SHALL be reported after reset deasserts until a new push occurs.

Configuration
REQ-028 Macro BUS_RESPONDER_TIMER_EN SHALL compile the TIMER feature in or out:
- Defined: TIMER behaves per REQ-025.
- Undefined: no timer register is synthesized, address 0x02 reads 0x00, and writes to 0x02 are ignored.

Structure
REQ-029 Package bus_responder_pkg SHALL hold:
- address constants ADDR_TXDATA, ADDR_STATUS, ADDR_TIMER, ADDR_DROPS
- STATUS bit-position constants
- the DROPS saturation value
REQ-030 The FIFO SHALL be a separate sub-module sync_fifo, with push/pop/full/empty/count, the same clock/reset convention, and parameters WIDTH and DEPTH.

Verification
REQ-031 Write 0xA5 to 0xE0, then read 0xE0 -> read_data=0xA5; read 0x04 -> 0x00.
REQ-032 With port_ready=0, push 0x11, 0x22, 0x33, 0x44, 0x55 to 0x00 -> STATUS=0x11 (full, count 4), DROPS=0x01; raise port_ready -> port_data shows 0x11, 0x22, 0x33, 0x44 on successive cycles, then port_valid=0 and STATUS=0x02.
REQ-033 FIFO full, port_ready=1, and a push of 0x66 in the same cycle -> occupancy stays 4, DROPS unchanged, and 0x66 emerges last.
REQ-034 Drop 300 pushes while full -> DROPS=0xFF; write 0x03 in the same cycle as a further drop -> DROPS=0x00.
REQ-035 With BUS_RESPONDER_TIMER_EN defined: write 0x02 at cycle N, read at N+5 -> 0x05; counter wraps 0xFF->0x00. With the macro undefined, 0x02 reads 0x00.
REQ-036 Three bytes queued, assert reset for one cycle mid-drain -> port_valid=0 immediately, STATUS=0x02 after release, and a previously written RAM byte reads back unchanged.

Source files
------------

// File: rtl/bus_responder_pkg.sv
// ---------------------------------------------------------------------------
// bus_responder_pkg
// Shared constants for the bus_responder slice: register addresses, STATUS
// bit layout, DROPS saturation value and a helper that packs STATUS.
// ---------------------------------------------------------------------------
package bus_responder_pkg;

  // Register addresses (RAM occupies the top of the 8-bit space)
  localparam logic [7:0] ADDR_TXDATA = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_TIMER  = 8'h02;
  localparam logic [7:0] ADDR_DROPS  = 8'h03;

  // STATUS layout: bit0 full, bit1 empty, bits[5:2] occupancy, bits[7:6] zero
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_COUNT_LSB = 2;
  localparam int STATUS_COUNT_W   = 4;

  // DROPS counter sticks at this value instead of wrapping
  localparam logic [7:0] DROPS_MAX = 8'hFF;

  function automatic logic [7:0] pack_status(
    input logic                      full,
    input logic                      empty,
    input logic [STATUS_COUNT_W-1:0] count
  );
    logic [7:0] status;
    status                                    = '0;
    status[STATUS_FULL_BIT]                   = full;
    status[STATUS_EMPTY_BIT]                  = empty;
    status[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
    return status;
  endfunction

endpackage

// File: rtl/bus_responder_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with no fall-through: a pushed entry becomes visible on
// the output side on the cycle after the push edge. Pointers wrap modulo
// DEPTH (power of two); occupancy is held in its own counter.
// A push while full is accepted only if a pop happens on the same edge.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset (empties the FIFO)
//   push       in   write request
//   push_data  in   WIDTH-bit data to write
//   pop        in   read request (ignored while empty)
//   pop_data   out  head entry, zero while empty
//   full       out  occupancy == DEPTH
//   empty      out  occupancy == 0
//   count      out  occupancy, clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  // When full, the slot under wr_ptr is the head being popped this edge,
  // so overwriting it is safe: the popped value was read before the edge.
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : fifo_mem[rd_ptr_reg];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; emptiness is defined by count_reg alone.
  always_ff @(posedge clock) begin
    if (do_push) fifo_mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/bus_responder.sv
// ---------------------------------------------------------------------------
// bus_responder
// Memory-mapped CPU slave: RAM at the top of the 8-bit space, a transmit
// FIFO fed through TXDATA and drained by a ready/valid port, a read-only
// STATUS register, a saturating DROPS counter and an optional free-running
// TIMER. Reads are combinational (zero wait states).
//
// Build option: define BUS_RESPONDER_TIMER_EN to include the TIMER register
// at 0x02; without it 0x02 reads 0x00 and ignores writes.
//
// Ports:
//   clock         in   rising-edge system clock
//   reset         in   asynchronous active-high reset (RAM is not cleared)
//   address       in   CPU byte address
//   write_enable  in   CPU write strobe
//   write_data    in   CPU store data
//   read_data     out  CPU load data (combinational)
//   port_data     out  FIFO head byte, 0x00 when empty
//   port_valid    out  FIFO not empty
//   port_ready    in   consumer accepts port_data
// ---------------------------------------------------------------------------
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int RAM_BYTES  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic       write_enable,
  input  logic [7:0] write_data,
  output logic [7:0] read_data,
  output logic [7:0] port_data,
  output logic       port_valid,
  input  logic       port_ready
);

  localparam int RAM_AW = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  // ---------------- RAM ----------------
  logic [7:0]        ram_mem [RAM_BYTES];
  logic              ram_hit;
  logic [RAM_AW-1:0] ram_index;

  assign ram_hit   = (9'(address) >= 9'(256 - RAM_BYTES));
  assign ram_index = address[RAM_AW-1:0] & RAM_AW'(RAM_BYTES - 1);

  always_ff @(posedge clock) begin
    if (write_enable && ram_hit) ram_mem[ram_index] <= write_data;
  end

  // ---------------- transmit FIFO ----------------
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             drop;

  assign fifo_push  = write_enable && (address == ADDR_TXDATA);
  assign fifo_pop   = port_valid && port_ready;
  assign port_valid = !fifo_empty;
  assign drop       = fifo_push && fifo_full && !fifo_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (write_data),
    .pop       (fifo_pop),
    .pop_data  (port_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------- DROPS ----------------
  logic [7:0] drops_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drops_reg <= 8'h00;
    end else if (write_enable && (address == ADDR_DROPS)) begin
      // Clear wins over a same-edge drop
      drops_reg <= 8'h00;
    end else if (drop && (drops_reg != DROPS_MAX)) begin
      drops_reg <= drops_reg + 8'h01;
    end
  end

  // ---------------- TIMER ----------------
`ifdef BUS_RESPONDER_TIMER_EN
  logic [7:0] timer_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_reg <= 8'h00;
    end else if (write_enable && (address == ADDR_TIMER)) begin
      timer_reg <= 8'h00;
    end else begin
      timer_reg <= timer_reg + 8'h01;
    end
  end
`endif

  // ---------------- read mux ----------------
  always_comb begin
    read_data = 8'h00;
    if (ram_hit) begin
      read_data = ram_mem[ram_index];
    end else begin
      case (address)
        ADDR_STATUS: read_data = pack_status(fifo_full, fifo_empty,
                                             STATUS_COUNT_W'(fifo_count));
        ADDR_DROPS:  read_data = drops_reg;
`ifdef BUS_RESPONDER_TIMER_EN
        ADDR_TIMER:  read_data = timer_reg;
`endif
        default:     read_data = 8'h00;
      endcase
    end
  end

endmodule
